// File: rtl/rom_fetch_ctrl.sv
// Read-side controller in front of a one-cycle-latency ROM: accepts single/burst
// word reads, paces ROM chip selects by FIFO credit, and returns data FWFT with a last marker.
module rom_fetch_ctrl #(
    parameter int unsigned Width     = 32,
    parameter int unsigned Depth     = 2048,
    parameter int unsigned Aw        = $clog2(Depth),
    parameter int unsigned LenW      = 4,
    parameter int unsigned FifoDepth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [LenW-1:0]  req_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_data_o,
    output logic             rsp_last_o,
    output logic [Aw-1:0]    rom_addr_o,
    output logic             rom_cs_o,
    input  logic [Width-1:0] rom_dout_i,
    input  logic             rom_dvalid_i,
    output logic             busy_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic             last;
        logic [Width-1:0] data;
    } rsp_beat_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e          state_q, state_d;
    logic [Aw-1:0]   addr_q, addr_d;
    logic [LenW-1:0] rem_q, rem_d;
    logic            issue_cs;
    logic            idle_ready;
    logic            last_beat;
    logic            credit;

    logic            inflight_q;
    logic            inflight_last_q;

    rsp_beat_t       mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW:0]   occupancy;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    rsp_beat_t       head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Credit counts words already buffered plus the one possibly in flight from the ROM.
    assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    assign credit    = occupancy < (CntW + 1)'(FifoDepth);
    assign last_beat = (rem_q == '0);

    // Next-state and issue logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue_cs   = 1'b0;
        idle_ready = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    rem_d   = req_len_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue_cs = 1'b1;
                    addr_d   = (addr_q == Aw'(Depth - 1)) ? '0 : addr_q + Aw'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - LenW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // In-flight tracking: the ROM answers exactly one cycle after each chip select.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q <= issue_cs;
            if (issue_cs) begin
                inflight_last_q <= last_beat;
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign push       = rom_dvalid_i & inflight_q;
    assign pop        = rsp_valid_o & rsp_ready_i;
    assign head       = mem_q[rd_ptr_q];

    // Storage carries no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{last: inflight_last_q, data: rom_dout_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // All host- and ROM-facing outputs read zero while reset is held.
    assign req_ready_o = rst_ni & idle_ready;
    assign rom_cs_o    = rst_ni & issue_cs;
    assign rom_addr_o  = rst_ni ? addr_q : '0;
    assign rsp_valid_o = rst_ni & ~fifo_empty;
    assign rsp_data_o  = rsp_valid_o ? head.data : '0;
    assign rsp_last_o  = rsp_valid_o & head.last;
    assign busy_o      = rst_ni & ((state_q == ISSUE) | inflight_q | ~fifo_empty);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: behavioural ROM, expected beats and
// ROM addresses queued at request acceptance and compared as the DUT produces them.
module tb_rom_fetch_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2000;
    localparam int unsigned AW    = 11;
    localparam int unsigned LENW  = 4;

    logic             clk;
    logic             rst_ni;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [LENW-1:0]  req_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_last;
    logic [AW-1:0]    rom_addr;
    logic             rom_cs;
    logic [WIDTH-1:0] rom_dout;
    logic             rom_dvalid_q;
    logic             inject_dvalid;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q [$];
    logic [AW-1:0]  addr_exp_q [$];

    rom_fetch_ctrl #(
        .Width    (WIDTH),
        .Depth    (DEPTH),
        .Aw       (AW),
        .LenW     (LENW),
        .FifoDepth(4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_last_o  (rsp_last),
        .rom_addr_o  (rom_addr),
        .rom_cs_o    (rom_cs),
        .rom_dout_i  (rom_dout),
        .rom_dvalid_i(rom_dvalid_q | inject_dvalid),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
        logic [WIDTH-1:0] w;
        if (a == AW'(16)) begin
            w = 32'hDEAD_BEEF;
        end else begin
            w = (32'(a) * 32'h9E37_79B9) ^ 32'h1234_5678;
        end
        return w;
    endfunction

    // ROM model: one-cycle read latency.
    always @(posedge clk) begin
        rom_dvalid_q <= rom_cs;
        if (rom_cs) begin
            rom_dout <= rom_word(rom_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: enqueue on accept, compare on every cs and every response handshake.
    always @(negedge clk) begin
        logic [AW-1:0]  a;
        logic [WIDTH:0] e;
        if (!rst_ni) begin
            exp_q.delete();
            addr_exp_q.delete();
        end else begin
            if (req_valid && req_ready) begin
                a = req_addr;
                for (int i = 0; i <= int'(req_len); i++) begin
                    exp_q.push_back({(i == int'(req_len)), rom_word(a)});
                    addr_exp_q.push_back(a);
                    a = (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
                end
            end
            if (rom_cs) begin
                if (addr_exp_q.size() == 0) begin
                    chk("cs_spurious", 64'(rom_cs), 64'd0);
                end else begin
                    a = addr_exp_q.pop_front();
                    chk("rom_addr", 64'(rom_addr), 64'(a));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e[WIDTH-1:0]));
                    chk("rsp_last", 64'(rsp_last), 64'(e[WIDTH]));
                end
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [LENW-1:0] l);
        int n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        chk("accept_wait", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        chk(tag, 64'(busy), 64'd0);
        chk({tag, "_drained"}, 64'(exp_q.size() + addr_exp_q.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        chk({tag, "_rsp_last"},  64'(rsp_last),  64'd0);
        chk({tag, "_rom_cs"},    64'(rom_cs),    64'd0);
        chk({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        int n_cs;
        int n_rsp;
        int n;
        rst_ni        = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_len       = '0;
        rsp_ready     = 1'b1;
        inject_dvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);

        // Single read with latency checks.
        do_req(AW'(16), 4'd0);
        @(negedge clk);
        chk("single_cs", 64'(rom_cs), 64'd1);
        chk("single_addr", 64'(rom_addr), 64'h10);
        @(negedge clk);
        chk("single_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        chk("single_rsp_last", 64'(rsp_last), 64'd1);
        @(negedge clk);
        chk("single_busy_clear", 64'(busy), 64'd0);

        // Burst of 8 at full throughput.
        do_req(AW'(12'h100), 4'd7);
        n_cs  = 0;
        n_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) chk("burst_cs_run", 64'(rom_cs), 64'd1);
            if (rom_cs) n_cs++;
            if (rsp_valid) n_rsp++;
        end
        chk("burst_cs_count", 64'(n_cs), 64'd8);
        chk("burst_rsp_count", 64'(n_rsp), 64'd8);
        wait_idle("burst_idle");

        // Backpressure: FIFO fills to 4 and issue stalls.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req(AW'(12'h020), 4'd15);
        n_cs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_cs) n_cs++;
        end
        chk("bp_cs_count", 64'(n_cs), 64'd4);
        chk("bp_cs_stalled", 64'(rom_cs), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_head_data", 64'(rsp_data), 64'(rom_word(AW'(12'h020))));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("bp_idle");

        // Address wrap at a non-power-of-2 depth.
        do_req(AW'(1998), 4'd3);
        wait_idle("wrap_idle");

        // Back-to-back requests, second held valid.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = AW'(12'h040);
        req_len   = 4'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        chk("b2b_first_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_addr = AW'(12'h080);
        req_len  = 4'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        chk("b2b_accept_gap", 64'(n), 64'd3);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle("b2b_idle");

        // Reset during beat 3 of an 8-beat burst, then a stray dvalid.
        do_req(AW'(12'h200), 4'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_ni        = 1'b1;
        inject_dvalid = 1'b1;
        @(posedge clk);
        #1;
        inject_dvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("post_rst_busy", 64'(busy), 64'd0);
        do_req(AW'(12'h300), 4'd0);
        wait_idle("post_rst_idle");
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
